// File: rtl/contador_pkg.sv
// contador_pkg: shared state encoding, direction constants and load saturation helper
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int unsigned sat_load(input int unsigned val, input int unsigned modulo);
        return (val >= modulo) ? modulo - 1 : val;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: prescaler emitting one tick every presc+1 enabled cycles
module divisor_tick #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pdiv_q, pdiv_d;

    // >= rather than == so lowering presc below pdiv ticks at once
    always_comb begin
        tick   = en && (pdiv_q >= presc);
        pdiv_d = clr ? '0 : !en ? pdiv_q : tick ? '0 : pdiv_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        pdiv_q <= reset ? '0 : pdiv_d;
    end

endmodule

// File: rtl/contador_modular.sv
// contador_modular: parametrised up/down modulo counter with load, prescaler,
// free-run/one-shot FSM and registered terminal-count pulse
module contador_modular
    import contador_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULO  = 256,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               one_shot,
    input  logic               start,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               busy
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   TERM = (WIDTH + 1)'(MODULO - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, next_cnt;
    logic             tc_q, tc_d, busy_q, busy_d, shot_q, shot_d;
    logic             up, tick, wrap, land;

    divisor_tick #(.PRESC_W(PRESC_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .clr   (load || start),
        .en    (en && (state_q == RUN)),
        .presc (presc),
        .tick  (tick)
    );

    // wrap is the free-run terminal transition; land ends a one-shot run
    always_comb begin
        up       = (up_dn == DIR_UP);
        wrap     = up ? ({1'b0, count_q} >= TERM) : (count_q == '0);
        next_cnt = wrap ? (up ? '0 : MAX) : (up ? count_q + 1'b1 : count_q - 1'b1);
        land     = shot_q && !wrap && (up ? ({1'b0, next_cnt} == TERM) : (next_cnt == '0));
        state_d  = state_q;
        count_d  = count_q;
        shot_d   = shot_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d = WIDTH'(sat_load(32'(load_val), 32'(MODULO)));
        end else if (start) begin
            state_d = RUN;
            shot_d  = one_shot;
            count_d = (up_dn == DIR_DN) ? MAX : '0;
        end else if (tick) begin
            count_d = next_cnt;
            tc_d    = wrap || land;
            state_d = land ? DONE : RUN;
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            shot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            shot_q  <= shot_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_contador_modular.sv
// tb_contador_modular: directed scoreboard bench for contador_modular (WIDTH=4, MODULO=10)
module tb_contador_modular;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load, one_shot, start;
    logic [3:0] load_val, presc, count;
    logic       tc, busy;

    typedef struct packed {
        logic [3:0] c;
        logic       t;
        logic       b;
    } exp_t;

    exp_t exp_q[$];
    int   errs = 0;
    int   checks = 0;

    contador_modular #(.WIDTH(4), .MODULO(10), .PRESC_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .one_shot (one_shot),
        .start    (start),
        .presc    (presc),
        .count    (count),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // expectation queued with the stimulus, popped and checked after the edge
    task automatic cyc(input logic [3:0] c, input logic t, input logic b);
        exp_t e;
        e.c = c;
        e.t = t;
        e.b = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errs++;
            $error("FAIL scoreboard: got empty queue expected entry");
        end
        e = exp_q.pop_front();
        checks++;
        assert (count === e.c) else begin
            errs++;
            $error("FAIL count @%0t: got %0d expected %0d", $time, count, e.c);
        end
        checks++;
        assert (tc === e.t) else begin
            errs++;
            $error("FAIL tc @%0t: got %b expected %b", $time, tc, e.t);
        end
        checks++;
        assert (busy === e.b) else begin
            errs++;
            $error("FAIL busy @%0t: got %b expected %b", $time, busy, e.b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; en = 0; up_dn = 1; load = 0; load_val = 0;
        one_shot = 0; start = 0; presc = 0;
        cyc(0, 0, 0);
        reset = 0; en = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        // free-run up
        start = 1;
        cyc(0, 0, 1);
        start = 0;
        for (int i = 1; i <= 9; i++) cyc(4'(i), 0, 1);
        cyc(0, 1, 1);
        cyc(1, 0, 1);
        // prescaler with enable pause
        presc = 2; start = 1;
        cyc(0, 0, 1);
        start = 0;
        cyc(0, 0, 1); cyc(0, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
        en = 0;
        repeat (5) cyc(1, 0, 1);
        en = 1;
        cyc(2, 0, 1); cyc(2, 0, 1); cyc(2, 0, 1); cyc(3, 0, 1);
        // one-shot down; one_shot dropped after start must not matter
        presc = 0; one_shot = 1; up_dn = 0; start = 1;
        cyc(9, 0, 1);
        start = 0; one_shot = 0;
        for (int i = 8; i >= 1; i--) cyc(4'(i), 0, 1);
        cyc(0, 1, 0);
        repeat (20) cyc(0, 0, 0);
        start = 1;
        cyc(9, 0, 1);
        start = 0;
        cyc(8, 0, 1);
        // load saturation and load-over-start priority
        load = 1; load_val = 13;
        cyc(9, 0, 1);
        load_val = 4; start = 1;
        cyc(4, 0, 1);
        start = 0; load = 0;
        cyc(3, 0, 1);
        // direction flips around the terminal values
        load = 1; load_val = 3; up_dn = 1;
        cyc(3, 0, 1);
        load = 0; up_dn = 0;
        cyc(2, 0, 1); cyc(1, 0, 1); cyc(0, 0, 1); cyc(9, 1, 1);
        up_dn = 1;
        cyc(0, 1, 1);
        for (int i = 1; i <= 6; i++) cyc(4'(i), 0, 1);
        // reset mid-run
        reset = 1;
        cyc(0, 0, 0);
        reset = 0;
        repeat (3) cyc(0, 0, 0);
        // one-shot entered at terminal via load wraps once before ending
        one_shot = 1; start = 1;
        cyc(0, 0, 1);
        start = 0; load = 1; load_val = 9;
        cyc(9, 0, 1);
        load = 0;
        cyc(0, 1, 1);
        for (int i = 1; i <= 8; i++) cyc(4'(i), 0, 1);
        cyc(9, 1, 0);
        cyc(9, 0, 0);
        load = 1; load_val = 2;
        cyc(2, 0, 0);
        load = 0;
        cyc(2, 0, 0);
        // lowering presc below pdiv ticks on the next enabled cycle
        one_shot = 0; presc = 5; start = 1;
        cyc(0, 0, 1);
        start = 0;
        cyc(0, 0, 1); cyc(0, 0, 1);
        presc = 1;
        cyc(1, 0, 1); cyc(1, 0, 1); cyc(2, 0, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
